program_counter_unit: RTL and testbench
=======================================

// Module: program_counter_unit
// PURPOSE
//  Parametrised program-counter stage for the fetch path. It holds the current instruction address and selects the next one.
//  Sources: sequential step, branch, jump, call/return via an internal return-address stack (RAS), exception vector.
//  Adds reset, stall and redirect priority to the basic next-address register. Sits between control/branch logic and instruction memory.
// PARAMETERS
//  ADDR_WIDTH        32            width of instruction_address and all targets
//  INSTR_BYTES       4             sequential step in bytes; power of 2
//  RESET_VECTOR      32'h0000_0000 instruction_address after reset
//  EXCEPTION_VECTOR  32'h8000_0180 target on exception
//  RAS_DEPTH         4             return-stack entries; power of 2, >= 2
// PORTS
//  clock                    in   1           rising-edge clock
//  reset                    in   1           synchronous, active-high
//  stall                    in   1           hold PC and RAS this cycle
//  exception                in   1           redirect to EXCEPTION_VECTOR
//  branch_taken             in   1           redirect to branch_target
//  branch_target            in   ADDR_WIDTH  branch destination
//  jump                     in   1           redirect to jump_target
//  call                     in   1           jump to jump_target, push return address
//  ret                      in   1           pop RAS, redirect to popped address
//  jump_target              in   ADDR_WIDTH  jump/call destination; fallback for ret on empty RAS
//  instruction_address      out  ADDR_WIDTH  registered current PC
//  next_sequential_address  out  ADDR_WIDTH  comb: instruction_address + INSTR_BYTES, mod 2^ADDR_WIDTH
//  ras_count                out  clog2(RAS_DEPTH)+1  valid entries, 0..RAS_DEPTH
//  ras_underflow            out  1           registered 1-cycle pulse: ret with empty RAS
//  misaligned_fault         out  1           registered 1-cycle pulse: taken target had nonzero low bits
// BEHAVIOUR
//  Reset: instruction_address=RESET_VECTOR, ras_count=0, RAS pointer=0, both pulse outputs=0. Reset wins over every input.
//  Priority per rising edge, highest first: reset > exception > stall > ret > call/jump > branch_taken > sequential.
//  exception: PC<=EXCEPTION_VECTOR even when stall=1. The RAS is untouched.
//  stall=1 without exception: PC, RAS and ras_count hold; pulses go 0. Redirects in that cycle are dropped; the requester re-presents them.
//  Sequential: PC<=PC+INSTR_BYTES. It wraps from all-ones to 0 without a flag.
//  jump/call target: jump_target with low log2(INSTR_BYTES) bits cleared. The same rule applies to branch_target.
//  If any cleared bit was 1, misaligned_fault=1 for the next cycle.
//  call: push PC+INSTR_BYTES, then redirect.
//  Call when full: overwrite the oldest entry (circular), ras_count stays RAS_DEPTH.
//  ret with ras_count>0: PC<=top entry, ras_count-1.
//  ret with ras_count=0: PC<=aligned jump_target, ras_underflow=1 next cycle, ras_count stays 0.
//  ret and call together: PC<=popped value (or the fallback). The top slot is replaced by PC+INSTR_BYTES, so ras_count is unchanged, or becomes 1 if it was 0.
//  jump and call together: treated as call.
//  branch_taken together with jump/call/ret: the branch is ignored.
//  Latency: one edge from a redirect input to the new instruction_address. There are no bubbles.
//  Pulse outputs are 0 in every cycle that follows no qualifying event.
// TESTING
//  1 Reset then 3 free cycles -> instruction_address 0x0,0x4,0x8,0xC; ras_count 0.
//  2 At PC=0x10: branch_taken, branch_target=0x40 -> next PC 0x40. branch_target=0x42 -> PC 0x40 and misaligned_fault pulse.
//  3 call to 0x100 from PC 0x20, then ret -> PC 0x100 then 0x24; ras_count 1 then 0.
//  4 Five nested calls with RAS_DEPTH=4, then five rets -> returns of the last 4 in LIFO order.
//     The fifth ret takes jump_target with a ras_underflow pulse.
//  5 stall=1 with jump to 0x200 -> PC holds. stall+exception -> PC 0x8000_0180, ras_count unchanged.
//  6 PC=0xFFFF_FFFC free-running -> 0x0. Reset asserted mid-stack -> PC 0x0, ras_count 0 on the next edge.

Source files
------------

// File: rtl/program_counter_unit.sv
// Program-counter stage for the fetch path.
// Holds the current instruction address and picks the next one from these
// sources: sequential step, branch, jump, call/return through a small
// circular return-address stack (RAS), or the exception vector.
// Priority per edge: reset > exception > stall > ret > call/jump > branch > sequential.
module program_counter_unit #(
    parameter int                    ADDR_WIDTH       = 32,
    parameter int                    INSTR_BYTES      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR     = 32'h0000_0000,
    parameter logic [ADDR_WIDTH-1:0] EXCEPTION_VECTOR = 32'h8000_0180,
    parameter int                    RAS_DEPTH        = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          stall,
    input  logic                          exception,
    input  logic                          branch_taken,
    input  logic [ADDR_WIDTH-1:0]         branch_target,
    input  logic                          jump,
    input  logic                          call,
    input  logic                          ret,
    input  logic [ADDR_WIDTH-1:0]         jump_target,
    output logic [ADDR_WIDTH-1:0]         instruction_address,
    output logic [ADDR_WIDTH-1:0]         next_sequential_address,
    output logic [$clog2(RAS_DEPTH):0]    ras_count,
    output logic                          ras_underflow,
    output logic                          misaligned_fault
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'(INSTR_BYTES - 1);
    localparam logic [CNT_W-1:0]      FULL_CNT = CNT_W'(RAS_DEPTH);

    // Registered state
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [PTR_W-1:0]      ptr_q;        // next free slot; top entry is ptr_q-1
    logic [CNT_W-1:0]      count_q;
    logic                  underflow_q;
    logic                  misalign_q;
    logic [ADDR_WIDTH-1:0] ras_mem [RAS_DEPTH];

    // Next-state values
    logic [ADDR_WIDTH-1:0] pc_d;
    logic [PTR_W-1:0]      ptr_d;
    logic [CNT_W-1:0]      count_d;
    logic                  underflow_d;
    logic                  misalign_d;
    logic                  wr_en;
    logic [PTR_W-1:0]      wr_idx;
    logic [ADDR_WIDTH-1:0] wr_data;

    // Derived addresses
    logic [ADDR_WIDTH-1:0] seq_addr;
    logic [ADDR_WIDTH-1:0] jump_aligned;
    logic [ADDR_WIDTH-1:0] branch_aligned;
    logic                  jump_misaligned;
    logic                  branch_misaligned;
    logic [PTR_W-1:0]      top_idx;
    logic [ADDR_WIDTH-1:0] ras_top;
    logic                  ras_empty;
    logic                  ras_full;

    // Target alignment, sequential step and stack-top lookup
    always_comb begin
        seq_addr          = pc_q + ADDR_WIDTH'(INSTR_BYTES);
        jump_aligned      = jump_target & ~LOW_MASK;
        branch_aligned    = branch_target & ~LOW_MASK;
        jump_misaligned   = |(jump_target & LOW_MASK);
        branch_misaligned = |(branch_target & LOW_MASK);
        top_idx           = ptr_q - PTR_W'(1);
        ras_top           = ras_mem[top_idx];
        ras_empty         = (count_q == '0);
        ras_full          = (count_q == FULL_CNT);
    end

    // Next-address selection and stack bookkeeping in priority order
    always_comb begin
        pc_d        = seq_addr;
        ptr_d       = ptr_q;
        count_d     = count_q;
        underflow_d = 1'b0;
        misalign_d  = 1'b0;
        wr_en       = 1'b0;
        wr_idx      = ptr_q;
        wr_data     = seq_addr;

        if (exception) begin
            // Exception overrides stall; the stack is left alone.
            pc_d = EXCEPTION_VECTOR;
        end else if (stall) begin
            // Any redirect presented this cycle is dropped.
            pc_d = pc_q;
        end else if (ret) begin
            if (!ras_empty) begin
                pc_d = ras_top;
                if (call) begin
                    // Pop and push cancel: overwrite the top slot in place.
                    wr_en  = 1'b1;
                    wr_idx = top_idx;
                end else begin
                    ptr_d   = top_idx;
                    count_d = count_q - CNT_W'(1);
                end
            end else begin
                // Empty stack: fall back to the jump target.
                pc_d        = jump_aligned;
                underflow_d = 1'b1;
                misalign_d  = jump_misaligned;
                if (call) begin
                    wr_en   = 1'b1;
                    wr_idx  = ptr_q;
                    ptr_d   = ptr_q + PTR_W'(1);
                    count_d = CNT_W'(1);
                end
            end
        end else if (call) begin
            // A full stack wraps and overwrites its oldest entry.
            pc_d       = jump_aligned;
            misalign_d = jump_misaligned;
            wr_en      = 1'b1;
            wr_idx     = ptr_q;
            ptr_d      = ptr_q + PTR_W'(1);
            count_d    = ras_full ? count_q : count_q + CNT_W'(1);
        end else if (jump) begin
            pc_d       = jump_aligned;
            misalign_d = jump_misaligned;
        end else if (branch_taken) begin
            pc_d       = branch_aligned;
            misalign_d = branch_misaligned;
        end
    end

    // PC, stack pointer, count and pulse registers
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q        <= RESET_VECTOR;
            ptr_q       <= '0;
            count_q     <= '0;
            underflow_q <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            ptr_q       <= ptr_d;
            count_q     <= count_d;
            underflow_q <= underflow_d;
            misalign_q  <= misalign_d;
        end
    end

    // Stack storage; contents past ras_count are don't-care so no reset needed
    always_ff @(posedge clock) begin
        if (!reset && wr_en) begin
            ras_mem[wr_idx] <= wr_data;
        end
    end

    assign instruction_address     = pc_q;
    assign next_sequential_address = seq_addr;
    assign ras_count               = count_q;
    assign ras_underflow           = underflow_q;
    assign misaligned_fault        = misalign_q;

endmodule

// File: tb/tb_program_counter_unit.sv
// Testbench for program_counter_unit: directed scenarios plus randomized
// traffic checked against a queue-based reference model.
module tb_program_counter_unit;

    logic        clock = 1'b0;
    logic        reset, stall, exception, branch_taken, jump, call, ret;
    logic [31:0] branch_target, jump_target;
    logic [31:0] instruction_address, next_sequential_address;
    logic [2:0]  ras_count;
    logic        ras_underflow, misaligned_fault;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_ras[$];
    logic        m_uf, m_mis;
    logic [31:0] exp_q[$];

    program_counter_unit dut (
        .clock(clock), .reset(reset), .stall(stall), .exception(exception),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .call(call), .ret(ret), .jump_target(jump_target),
        .instruction_address(instruction_address),
        .next_sequential_address(next_sequential_address),
        .ras_count(ras_count), .ras_underflow(ras_underflow),
        .misaligned_fault(misaligned_fault)
    );

    // clock / reset block
    always #5 clock = ~clock;

    task automatic idle();
        reset = 0; stall = 0; exception = 0; branch_taken = 0;
        jump = 0; call = 0; ret = 0; branch_target = 0; jump_target = 0;
    endtask

    task automatic model_push(input logic [31:0] v);
        if (m_ras.size() == 4) void'(m_ras.pop_front());
        m_ras.push_back(v);
    endtask

    // Reference behaviour of one rising edge, from the priority rules
    task automatic model_step();
        logic [31:0] tgt;
        m_uf = 0; m_mis = 0;
        if (reset) begin
            m_pc = 32'h0; m_ras.delete();
        end else if (exception) begin
            m_pc = 32'h8000_0180;
        end else if (stall) begin
            m_pc = m_pc;
        end else if (ret) begin
            if (m_ras.size() > 0) tgt = m_ras.pop_back();
            else begin
                tgt = {jump_target[31:2], 2'b00};
                m_uf = 1; m_mis = (jump_target[1:0] != 0);
            end
            if (call) model_push(m_pc + 4);
            m_pc = tgt;
        end else if (call) begin
            model_push(m_pc + 4);
            m_mis = (jump_target[1:0] != 0);
            m_pc = {jump_target[31:2], 2'b00};
        end else if (jump) begin
            m_mis = (jump_target[1:0] != 0);
            m_pc = {jump_target[31:2], 2'b00};
        end else if (branch_taken) begin
            m_mis = (branch_target[1:0] != 0);
            m_pc = {branch_target[31:2], 2'b00};
        end else begin
            m_pc = m_pc + 4;
        end
    endtask

    // driver: apply current inputs for one edge, then sample 1ns later
    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        idle(); reset = 1; tick(); tick(); reset = 0;
        checks++; if (instruction_address !== 32'h0) begin errors++;
            $display("FAIL reset_pc got %h want %h", instruction_address, 32'h0); end
        checks++; if (ras_count !== 3'd0) begin errors++;
            $display("FAIL reset_count got %0d want 0", ras_count); end
        checks++; if (ras_underflow !== 1'b0 || misaligned_fault !== 1'b0) begin errors++;
            $display("FAIL reset_pulses got %b%b want 00", ras_underflow, misaligned_fault); end
        checks++; if (next_sequential_address !== 32'h4) begin errors++;
            $display("FAIL reset_nsa got %h want %h", next_sequential_address, 32'h4); end
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++; if (instruction_address !== 32'(i * 4) || ras_count !== 3'd0) begin errors++;
                $display("FAIL free_run got %h/%0d want %h/0", instruction_address, ras_count, 32'(i * 4)); end
        end
    endtask

    task automatic test_branch();
        idle(); jump = 1; jump_target = 32'h10; tick(); idle();
        checks++; if (instruction_address !== 32'h10) begin errors++;
            $display("FAIL jump_pc got %h want %h", instruction_address, 32'h10); end
        branch_taken = 1; branch_target = 32'h40; tick(); idle();
        checks++; if (instruction_address !== 32'h40 || misaligned_fault !== 1'b0) begin errors++;
            $display("FAIL branch_pc got %h/%b want 00000040/0", instruction_address, misaligned_fault); end
        jump = 1; jump_target = 32'h10; tick(); idle();
        branch_taken = 1; branch_target = 32'h42; tick(); idle();
        checks++; if (instruction_address !== 32'h40 || misaligned_fault !== 1'b1) begin errors++;
            $display("FAIL branch_misaligned got %h/%b want 00000040/1", instruction_address, misaligned_fault); end
        tick();
        checks++; if (misaligned_fault !== 1'b0 || instruction_address !== 32'h44) begin errors++;
            $display("FAIL fault_clear got %h/%b want 00000044/0", instruction_address, misaligned_fault); end
    endtask

    task automatic test_call_ret();
        idle(); jump = 1; jump_target = 32'h20; tick(); idle();
        call = 1; jump_target = 32'h100; tick(); idle();
        checks++; if (instruction_address !== 32'h100 || ras_count !== 3'd1) begin errors++;
            $display("FAIL call_pc got %h/%0d want 00000100/1", instruction_address, ras_count); end
        ret = 1; tick(); idle();
        checks++; if (instruction_address !== 32'h24 || ras_count !== 3'd0 || ras_underflow !== 1'b0) begin errors++;
            $display("FAIL ret_pc got %h/%0d/%b want 00000024/0/0", instruction_address, ras_count, ras_underflow); end
    endtask

    task automatic test_nested_calls();
        logic [31:0] exp;
        exp_q.delete();
        idle(); jump = 1; jump_target = 32'h800; tick(); idle();
        for (int i = 1; i <= 5; i++) begin
            exp_q.push_back(instruction_address + 4);
            call = 1; jump_target = 32'(i * 32'h1000); tick(); idle();
        end
        void'(exp_q.pop_front());  // oldest return address overwritten
        checks++; if (ras_count !== 3'd4 || instruction_address !== 32'h5000) begin errors++;
            $display("FAIL nested_full got %h/%0d want 00005000/4", instruction_address, ras_count); end
        for (int k = 0; k < 4; k++) begin
            exp = exp_q.pop_back();
            ret = 1; tick(); idle();
            checks++; if (instruction_address !== exp || ras_count !== 3'(3 - k)) begin errors++;
                $display("FAIL nested_ret got %h/%0d want %h/%0d", instruction_address, ras_count, exp, 3 - k); end
        end
        ret = 1; jump_target = 32'h700; tick(); idle();
        checks++; if (instruction_address !== 32'h700 || ras_underflow !== 1'b1 || ras_count !== 3'd0) begin errors++;
            $display("FAIL underflow got %h/%b/%0d want 00000700/1/0", instruction_address, ras_underflow, ras_count); end
        tick();
        checks++; if (ras_underflow !== 1'b0 || instruction_address !== 32'h704) begin errors++;
            $display("FAIL underflow_clear got %h/%b want 00000704/0", instruction_address, ras_underflow); end
    endtask

    task automatic test_stall_exception();
        logic [31:0] held;
        idle(); call = 1; jump_target = 32'h300; tick(); idle();
        held = instruction_address;
        stall = 1; jump = 1; jump_target = 32'h200; tick(); idle();
        checks++; if (instruction_address !== held || ras_count !== 3'd1) begin errors++;
            $display("FAIL stall_hold got %h/%0d want %h/1", instruction_address, ras_count, held); end
        stall = 1; exception = 1; ret = 1; tick(); idle();
        checks++; if (instruction_address !== 32'h8000_0180 || ras_count !== 3'd1) begin errors++;
            $display("FAIL stall_exception got %h/%0d want 80000180/1", instruction_address, ras_count); end
    endtask

    task automatic test_wrap_and_reset();
        idle(); jump = 1; jump_target = 32'hFFFF_FFFC; tick(); idle();
        checks++; if (next_sequential_address !== 32'h0) begin errors++;
            $display("FAIL nsa_wrap got %h want 00000000", next_sequential_address); end
        tick();
        checks++; if (instruction_address !== 32'h0) begin errors++;
            $display("FAIL pc_wrap got %h want 00000000", instruction_address); end
        call = 1; jump_target = 32'h400; tick(); tick(); idle();
        reset = 1; call = 1; jump_target = 32'h500; tick(); idle();
        checks++; if (instruction_address !== 32'h0 || ras_count !== 3'd0) begin errors++;
            $display("FAIL mid_reset got %h/%0d want 00000000/0", instruction_address, ras_count); end
    endtask

    // Randomized traffic, every output compared with the model each cycle
    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            reset        = ($urandom_range(0, 99) == 0);
            exception    = ($urandom_range(0, 29) == 0);
            stall        = ($urandom_range(0, 7) == 0);
            ret          = ($urandom_range(0, 4) == 0);
            call         = ($urandom_range(0, 4) == 0);
            jump         = ($urandom_range(0, 5) == 0);
            branch_taken = ($urandom_range(0, 3) == 0);
            branch_target = $urandom;
            jump_target   = $urandom;
            if (ret) jump_target[1:0] = 2'b00;
            tick();
            checks++;
            if (instruction_address !== m_pc || next_sequential_address !== m_pc + 32'd4 ||
                ras_count !== 3'(m_ras.size()) || ras_underflow !== m_uf || misaligned_fault !== m_mis) begin
                errors++;
                $display("FAIL random[%0d] got pc=%h nsa=%h cnt=%0d uf=%b mis=%b want pc=%h nsa=%h cnt=%0d uf=%b mis=%b",
                         n, instruction_address, next_sequential_address, ras_count, ras_underflow, misaligned_fault,
                         m_pc, m_pc + 32'd4, m_ras.size(), m_uf, m_mis);
            end
        end
        idle();
    endtask

    initial begin
        idle();
        m_pc = 0; m_uf = 0; m_mis = 0;
        test_reset();
        test_branch();
        test_call_ret();
        test_nested_calls();
        test_stall_exception();
        test_wrap_and_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
